mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped console transmitter that answers CPU load/store commands on the data-memory bus.
//  Each store to TXDATA queues one byte in a FIFO. An 8N1 serializer drains the FIFO onto txd.
//  Sits beside the data memory: the CPU's address/mem_cmd/write-data feed both units, and the top
//  level selects rd_data over memory data when hit=1. Replaces the SYSCALL-1 $display path on silicon.
// PARAMETERS
//  BASE_ADDR     32'h1000_0000  word-aligned base of the 16-byte register window
//  FIFO_DEPTH    8              TX FIFO entries; must be a power of 2 and >= 2
//  CLKS_PER_BIT  868            clk cycles per serial bit; must be >= 2
// PORTS
//  clk      in   1       single clock; all state updates on posedge
//  rst      in   1       asynchronous, active-high reset
//  addr     in   W_CPU   byte address from the ALU result
//  mem_cmd  in   W_MEM_CMD  bus command, decoded with the `MEM_* encodings in lib/opcodes.v
//  wdata    in   W_CPU   store data (rt)
//  rdata    out  W_CPU   load data; combinational; 0 when hit=0
//  hit      out  1       addr[31:4]==BASE_ADDR[31:4] and mem_cmd is a read or a write
//  txd      out  1       serial line; idle high
//  irq      out  1       CTRL.irq_en & fifo_empty & ~busy
// BEHAVIOUR
//  Register map (addr[3:2]); addr[1:0] ignored:
//   0 TXDATA  W: push wdata[7:0] to the FIFO. R: 0.
//   1 STATUS  R: [0] full, [1] empty, [2] busy, [3] ovf (sticky), [7:4] count (saturates at 15),
//             all other bits 0. W: writing wdata[3]=1 clears ovf.
//   2 CTRL    R/W: [0] tx_en (reset 1), [1] irq_en (reset 0). Other bits read as 0.
//   3 --      R: 0. W: ignored.
//  Reads are combinational, so a load completes in the same cycle as the single-cycle CPU.
//  Writes take effect at the posedge where hit=1 and mem_cmd is a write.
//  Reset (async): FIFO empty, pointers 0, ovf=0, tx_en=1, irq_en=0, FSM=IDLE, txd=1,
//   rdata=0, irq=0.
//  FIFO:
//   - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//   - full: pointer MSBs differ and the low bits are equal. empty: pointers equal.
//  Push on a full FIFO with no pop in the same cycle: byte dropped, ovf<=1.
//  Push and pop in the same cycle: both occur, including when full. Count is unchanged.
//  Serializer FSM; bit_cnt counts 0..CLKS_PER_BIT-1:
//   IDLE : txd=1. If tx_en and !empty: pop the FIFO head into shreg -> START.
//   START: txd=0 for CLKS_PER_BIT cycles -> DATA with bit_idx=0.
//   DATA : txd=shreg[0], LSB first. Shift at the end of each bit. After bit 7 -> STOP.
//   STOP : txd=1 for CLKS_PER_BIT cycles -> IDLE.
//  busy=1 in every state except IDLE.
//  One frame lasts 10*CLKS_PER_BIT cycles. Back-to-back frames add 1 IDLE cycle between them.
//  tx_en=0 blocks only the IDLE->START transition. A frame already in flight completes.
//  txd is driven from a register, so there is no combinational glitch on the pin.
//  Reset mid-frame aborts the frame immediately: txd=1 and queued bytes are lost.
// STRUCTURE
//  Header lib/uart_regs.v defines:
//   - `UART_REG_TXDATA/STATUS/CTRL (2'd0..2)
//   - the STATUS bit indices
//   - FSM state encodings `UTX_IDLE/START/DATA/STOP (2 bits)
//  Sub-module sync_fifo (params WIDTH=8, DEPTH) provides push, pop, dout, full, empty, count.
//  The top level contains the register decode, ovf/CTRL flops, serializer FSM and the irq term.
// TESTING
//  Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, and a bit-sampling monitor on txd.
//  1. Reset with no traffic -> txd=1, STATUS read = 32'h0000_0002, CTRL read = 32'h1, irq=0.
//  2. Store 32'hFFFF_FF55 to BASE_ADDR -> line shows start=0, bits 1,0,1,0,1,0,1,0, stop=1,
//     over 40 cycles. busy=1 throughout the frame. STATUS returns to 0x2 afterwards.
//  3. Store 6 bytes 0x41..0x46 back-to-back -> bytes 0x41..0x45 are transmitted in order
//     (the FIFO holds 4, and 0x41 was popped after 1 cycle). 0x46 is dropped, STATUS[3]=1.
//     Storing 0x8 to BASE+4 clears STATUS[3].
//  4. Write CTRL=0, then store 0x33 -> txd stays 1, STATUS.count=1. Write CTRL=1 -> frame
//     starts within 2 cycles.
//  5. Set CTRL=2, store 0x7E -> irq=0 during the frame, irq=1 one cycle after STOP ends.
//  6. Assert rst during DATA bit 3 -> txd=1 immediately, FIFO empty. Load from
//     BASE+8 with addr outside the window -> hit=0, rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//  - CPU bus widths and mem_cmd encodings
//  - register offsets within the 16-byte window (selected by addr[3:2])
//  - STATUS bit positions
//  - serializer state encoding
//  - helper that saturates a FIFO occupancy to the 4-bit STATUS.count field
package mmio_uart_tx_pkg;

    localparam int W_CPU     = 32;
    localparam int W_MEM_CMD = 2;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_e;

    // Occupancy above 15 is reported as 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        if (cnt > 32'd15) begin
            return 4'hF;
        end else begin
            return cnt[3:0];
        end
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO for the UART transmit path.
//  clk, rst     : clock, asynchronous active-high reset
//  push, din    : write strobe and data (ignored when full unless pop is also set)
//  pop, dout    : read strobe and head-of-queue data (dout valid whenever !empty)
//  full, empty  : occupancy flags
//  count        : number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty = (wptr_r == rptr_r);
    assign count = wptr_r - rptr_r;
    assign dout  = mem_r[rptr_r[AW-1:0]];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push_s = push & (~full | pop);
    assign do_pop_s  = pop & ~empty;

    // Read/write pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because empty gates their use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter on the data-memory bus.
//  clk, rst : clock, asynchronous active-high reset
//  addr     : CPU byte address; window is BASE_ADDR..BASE_ADDR+15, register = addr[3:2]
//  mem_cmd  : bus command (MEM_READ / MEM_WRITE select this unit)
//  wdata    : store data
//  rdata    : combinational load data, zero when hit=0
//  hit      : address in window and command is a read or write
//  txd      : registered serial output, idle high
//  irq      : registered, irq_en & fifo empty & serializer idle
// Registers: 0 TXDATA (W push), 1 STATUS (R flags, W bit3 clears ovf), 2 CTRL (tx_en, irq_en).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_CPU-1:0]     addr,
    input  logic [W_MEM_CMD-1:0] mem_cmd,
    input  logic [W_CPU-1:0]     wdata,
    output logic [W_CPU-1:0]     rdata,
    output logic                 hit,
    output logic                 txd,
    output logic                 irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             hit_s, wr_s, push_s, pop_s, busy_s, bit_end_s;
    logic [1:0]       sel_s;
    logic [7:0]       fifo_dout_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [W_CPU-1:0] status_s;
    logic             unused_s;

    logic             ovf_r, tx_en_r, irq_en_r, irq_r, txd_r;
    utx_state_e       state_r, state_next;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_next;
    logic [2:0]       bit_idx_r, bit_idx_next;
    logic [7:0]       shreg_r, shreg_next;
    logic             txd_next;

    assign hit_s  = (addr[31:4] == BASE_ADDR[31:4]) &&
                    ((mem_cmd == MEM_READ) || (mem_cmd == MEM_WRITE));
    assign wr_s   = hit_s && (mem_cmd == MEM_WRITE);
    assign sel_s  = addr[3:2];
    assign push_s = wr_s && (sel_s == UART_REG_TXDATA);
    assign busy_s = (state_r != UTX_IDLE);
    assign bit_end_s = (bit_cnt_r == CNT_MAX);
    assign unused_s  = ^{addr[1:0], wdata[W_CPU-1:8]};

    assign hit  = hit_s;
    assign txd  = txd_r;
    assign irq  = irq_r;

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (wdata[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign status_s = {{(W_CPU-8){1'b0}}, sat_count4(32'(fifo_count_s)),
                       ovf_r, busy_s, fifo_empty_s, fifo_full_s};

    // Combinational load data so a load completes in the same CPU cycle.
    always_comb begin
        rdata = {W_CPU{1'b0}};
        if (hit_s) begin
            case (sel_s)
                UART_REG_STATUS: rdata = status_s;
                UART_REG_CTRL:   rdata = {{(W_CPU-2){1'b0}}, irq_en_r, tx_en_r};
                default:         rdata = {W_CPU{1'b0}};
            endcase
        end else begin
            rdata = {W_CPU{1'b0}};
        end
    end

    // Control/status flops and the registered interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r    <= 1'b0;
            tx_en_r  <= 1'b1;
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            // A dropped byte takes priority over a clear in the same cycle.
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (wr_s && (sel_s == UART_REG_STATUS) && wdata[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
            if (wr_s && (sel_s == UART_REG_CTRL)) begin
                tx_en_r  <= wdata[0];
                irq_en_r <= wdata[1];
            end
            irq_r <= irq_en_r & fifo_empty_s & ~busy_s;
        end
    end

    // Serializer next-state, bit timing and the next value of the txd pin.
    always_comb begin
        state_next   = state_r;
        bit_cnt_next = bit_cnt_r;
        bit_idx_next = bit_idx_r;
        shreg_next   = shreg_r;
        pop_s        = 1'b0;
        txd_next     = 1'b1;
        case (state_r)
            UTX_IDLE: begin
                if (tx_en_r && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shreg_next   = fifo_dout_s;
                    bit_cnt_next = CNT_ZERO;
                    state_next   = UTX_START;
                end else begin
                    state_next = UTX_IDLE;
                end
            end
            UTX_START: begin
                if (bit_end_s) begin
                    bit_cnt_next = CNT_ZERO;
                    bit_idx_next = 3'd0;
                    state_next   = UTX_DATA;
                end else begin
                    bit_cnt_next = bit_cnt_r + CNT_ONE;
                end
            end
            UTX_DATA: begin
                if (bit_end_s) begin
                    bit_cnt_next = CNT_ZERO;
                    shreg_next   = {1'b0, shreg_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_next = UTX_STOP;
                    end else begin
                        bit_idx_next = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_r + CNT_ONE;
                end
            end
            UTX_STOP: begin
                if (bit_end_s) begin
                    bit_cnt_next = CNT_ZERO;
                    state_next   = UTX_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next = UTX_IDLE;
            end
        endcase
        // The pin follows the state being entered so txd and state stay aligned.
        case (state_next)
            UTX_START: txd_next = 1'b0;
            UTX_DATA:  txd_next = shreg_next[0];
            default:   txd_next = 1'b1;
        endcase
    end

    // Serializer state registers, including the glitch-free txd flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= UTX_IDLE;
            bit_cnt_r <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_next;
            bit_cnt_r <= bit_cnt_next;
            bit_idx_r <= bit_idx_next;
            shreg_r   <= shreg_next;
            txd_r     <= txd_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A bit-sampling monitor reads txd in the middle of each serial bit.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [1:0]  mem_cmd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit, txd, irq;

    int tests  = 0;
    int failed = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .mem_cmd (mem_cmd),
        .wdata   (wdata),
        .rdata   (rdata),
        .hit     (hit),
        .txd     (txd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; the write lands on the next posedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wdata   = d;
        mem_cmd = MEM_WRITE;
        @(posedge clk);
        #1;
        mem_cmd = MEM_NOP;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr    = a;
        mem_cmd = MEM_READ;
        #1;
        d = rdata;
        h = hit;
        mem_cmd = MEM_NOP;
    endtask

    task automatic side_check(input bit chk_busy, input bit chk_irq, inout logic ok);
        logic [31:0] d;
        logic        h;
        if (chk_busy) begin
            bus_read(BASE + 32'd4, d, h);
            if (d[2] !== 1'b1) ok = 1'b0;
        end
        if (chk_irq && (irq !== 1'b0)) ok = 1'b0;
    endtask

    // Waits up to 'limit' cycles for a start bit, then samples the frame mid-bit.
    // Returns at the middle of the stop bit (start cycle + 38).
    task automatic capture(input int limit, input bit chk_busy, input bit chk_irq,
                           output logic [7:0] b, output logic found,
                           output logic start_ok, output logic stop_ok, output logic side_ok);
        found = 1'b0; start_ok = 1'b0; stop_ok = 1'b0; side_ok = 1'b1; b = 8'h00;
        for (int i = 0; i < limit && !found; i++) begin
            if (txd === 1'b0) found = 1'b1;
            else tick();
        end
        if (found) begin
            side_check(chk_busy, chk_irq, side_ok);
            repeat (2) tick();
            start_ok = (txd === 1'b0);
            side_check(chk_busy, chk_irq, side_ok);
            for (int j = 0; j < 8; j++) begin
                repeat (4) tick();
                b[j] = txd;
                side_check(chk_busy, chk_irq, side_ok);
            end
            repeat (4) tick();
            stop_ok = (txd === 1'b1);
            side_check(chk_busy, chk_irq, side_ok);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h, fnd, st, sp, sd, hold;
        logic [7:0]  b;

        rst = 1'b1; addr = 32'h0; mem_cmd = MEM_NOP; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        check("t1_txd", 32'(txd), 32'd1);
        check("t1_irq", 32'(irq), 32'd0);
        bus_read(BASE + 32'd4, d, h);
        check("t1_status", d, 32'h2);
        check("t1_hit", 32'(h), 32'd1);
        bus_read(BASE + 32'd8, d, h);
        check("t1_ctrl", d, 32'h1);
        tick();

        // 2: single frame 0x55 with busy held for the whole frame
        bus_write(BASE, 32'hFFFF_FF55);
        capture(8, 1'b1, 1'b0, b, fnd, st, sp, sd);
        check("t2_frame", {21'd0, fnd, st, sp, b}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h55});
        check("t2_busy", 32'(sd), 32'd1);
        tick();
        bus_read(BASE + 32'd4, d, h);
        check("t2_status_last_stop", d, 32'h6);
        tick();
        bus_read(BASE + 32'd4, d, h);
        check("t2_status_idle", d, 32'h2);

        // 3: six back-to-back stores, FIFO of 4 drops the sixth
        fork
            begin
                logic [31:0] d3;
                logic        h3;
                for (int k = 0; k < 6; k++) bus_write(BASE, 32'(32'h41 + k));
                bus_read(BASE + 32'd4, d3, h3);
                check("t3_status_ovf", d3, 32'h4D);
            end
            begin
                logic [7:0] b3;
                logic       f3, s3, p3, o3;
                for (int k = 0; k < 5; k++) begin
                    capture(60, 1'b0, 1'b0, b3, f3, s3, p3, o3);
                    check("t3_frame", {21'd0, f3, s3, p3, b3},
                          {21'd0, 1'b1, 1'b1, 1'b1, 8'(8'h41 + k)});
                end
            end
        join
        repeat (4) tick();
        bus_read(BASE + 32'd4, d, h);
        check("t3_status_ovf_idle", d, 32'h0A);
        bus_write(BASE + 32'd4, 32'h8);
        bus_read(BASE + 32'd4, d, h);
        check("t3_ovf_cleared", d, 32'h2);
        hold = 1'b1;
        repeat (50) begin tick(); if (txd !== 1'b1) hold = 1'b0; end
        check("t3_no_sixth_frame", 32'(hold), 32'd1);

        // 4: tx_en=0 holds the byte in the FIFO
        bus_write(BASE + 32'd8, 32'h0);
        bus_write(BASE, 32'h33);
        hold = 1'b1;
        repeat (10) begin tick(); if (txd !== 1'b1) hold = 1'b0; end
        check("t4_txd_held", 32'(hold), 32'd1);
        bus_read(BASE + 32'd4, d, h);
        check("t4_status_count1", d, 32'h10);
        bus_read(BASE + 32'd8, d, h);
        check("t4_ctrl", d, 32'h0);
        bus_write(BASE + 32'd8, 32'h1);
        capture(2, 1'b0, 1'b0, b, fnd, st, sp, sd);
        check("t4_frame_fast", {21'd0, fnd, st, sp, b}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h33});
        repeat (3) tick();

        // 5: interrupt on drain
        bus_write(BASE + 32'd8, 32'h2);
        check("t5_irq_lag", 32'(irq), 32'd0);
        tick();
        check("t5_irq_idle", 32'(irq), 32'd1);
        bus_write(BASE, 32'h7E);
        check("t5_irq_before_push_seen", 32'(irq), 32'd1);
        tick();
        check("t5_irq_nonempty", 32'(irq), 32'd0);
        bus_write(BASE + 32'd8, 32'h3);
        capture(4, 1'b0, 1'b1, b, fnd, st, sp, sd);
        check("t5_frame", {21'd0, fnd, st, sp, b}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h7E});
        check("t5_irq_low_in_frame", 32'(sd), 32'd1);
        repeat (2) tick();
        check("t5_irq_first_idle", 32'(irq), 32'd0);
        tick();
        check("t5_irq_rise", 32'(irq), 32'd1);

        // 6: reset during DATA bit 3 aborts the frame and flushes the FIFO
        bus_write(BASE + 32'd8, 32'h1);
        bus_write(BASE, 32'hA5);
        bus_write(BASE, 32'h5A);
        fnd = 1'b0;
        for (int i = 0; i < 8 && !fnd; i++) begin
            if (txd === 1'b0) fnd = 1'b1;
            else tick();
        end
        check("t6_start_seen", 32'(fnd), 32'd1);
        repeat (18) tick();
        check("t6_bit3_low", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_txd_on_rst", 32'(txd), 32'd1);
        bus_read(BASE + 32'd4, d, h);
        check("t6_status_in_rst", d, 32'h2);
        tick();
        rst = 1'b0;
        hold = 1'b1;
        repeat (50) begin tick(); if (txd !== 1'b1) hold = 1'b0; end
        check("t6_queue_lost", 32'(hold), 32'd1);
        bus_read(BASE + 32'd8, d, h);
        check("t6_ctrl_reset", d, 32'h1);
        bus_read(32'h2000_0008, d, h);
        check("t6_outside_hit", 32'(h), 32'd0);
        check("t6_outside_rdata", d, 32'h0);
        bus_read(BASE + 32'h18, d, h);
        check("t6_next_window_hit", 32'(h), 32'd0);
        addr = BASE + 32'd8;
        mem_cmd = MEM_NOP;
        #1;
        check("t6_nop_hit", 32'(hit), 32'd0);
        check("t6_nop_rdata", rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
